// File: rtl/code_entry_checker.sv
// Keypad code entry checker: gathers digits, compares them incrementally against the
// stored combination, and emits a one-cycle check strobe with a match bit. Also handles
// the inactivity timeout, consecutive-failure counting and timed lockout.
module code_entry_checker #(
    parameter int unsigned                 DIGIT_W     = 4,
    parameter int unsigned                 CODE_LEN    = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] CODE        = 16'h1234,
    parameter int unsigned                 TIMEOUT     = 1000,
    parameter int unsigned                 MAX_FAILS   = 3,
    parameter int unsigned                 LOCK_CYCLES = 5000
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             digit_valid,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             clear,
    output logic                             check_en,
    output logic                             check_match,
    output logic [$clog2(CODE_LEN+1)-1:0]    digit_count,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
    output logic                             locked_out,
    output logic                             busy
);

    localparam int unsigned CntW  = $clog2(CODE_LEN + 1);
    localparam int unsigned FailW = $clog2(MAX_FAILS + 1);
    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
    localparam int unsigned LockW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StEntry, StCheck, StLockout} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               mism_q, mism_d;
    logic [IdleW-1:0]   idle_q, idle_d;
    logic [LockW-1:0]   lock_q, lock_d;
    logic [FailW-1:0]   fail_q, fail_d;
    logic               check_en_q, check_en_d;
    logic               check_match_q, check_match_d;
    logic               locked_out_q, locked_out_d;
    logic               busy_q, busy_d;

    logic [DIGIT_W-1:0] code_digit;
    logic               last_digit;
    logic [FailW-1:0]   fail_inc;

    // Select the stored digit expected at the current position (first digit is the MSB).
    always_comb begin
        code_digit = '0;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (cnt_q == CntW'(i)) begin
                code_digit = CODE[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign last_digit = (cnt_q == CntW'(CODE_LEN - 1));
    assign fail_inc   = (fail_q == FailW'(MAX_FAILS)) ? fail_q : fail_q + FailW'(1);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mism_d  = mism_q;
        idle_d  = '0;
        lock_d  = '0;
        fail_d  = fail_q;
        unique case (state_q)
            StIdle: begin
                // cnt_q and mism_q are always zero here, so accumulation starts clean.
                if (digit_valid && !clear) begin
                    cnt_d   = cnt_q + CntW'(1);
                    mism_d  = mism_q | (digit != code_digit);
                    state_d = last_digit ? StCheck : StEntry;
                end
            end
            StEntry: begin
                if (clear) begin
                    cnt_d   = '0;
                    mism_d  = 1'b0;
                    state_d = StIdle;
                end else if (digit_valid) begin
                    cnt_d   = cnt_q + CntW'(1);
                    mism_d  = mism_q | (digit != code_digit);
                    state_d = last_digit ? StCheck : StEntry;
                end else if (idle_q == IdleW'(TIMEOUT - 1)) begin
                    // Timer would reach TIMEOUT: drop the partial entry silently.
                    cnt_d   = '0;
                    mism_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    idle_d = idle_q + IdleW'(1);
                end
            end
            StCheck: begin
                cnt_d  = '0;
                mism_d = 1'b0;
                if (!mism_q) begin
                    fail_d  = '0;
                    state_d = StIdle;
                end else begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc == FailW'(MAX_FAILS)) ? StLockout : StIdle;
                end
            end
            StLockout: begin
                if (lock_q == LockW'(LOCK_CYCLES - 1)) begin
                    fail_d  = '0;
                    state_d = StIdle;
                end else begin
                    lock_d = lock_q + LockW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                mism_d  = 1'b0;
                fail_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Output next values, decoded from the next state so the outputs are registered.
    always_comb begin
        check_en_d    = (state_d == StCheck);
        check_match_d = (state_d == StCheck) ? !mism_d : check_match_q;
        locked_out_d  = (state_d == StLockout);
        busy_d        = (state_d == StEntry) || (state_d == StCheck);
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q         <= '0;
            mism_q        <= 1'b0;
            idle_q        <= '0;
            lock_q        <= '0;
            fail_q        <= '0;
            check_en_q    <= 1'b0;
            check_match_q <= 1'b0;
            locked_out_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            mism_q        <= mism_d;
            idle_q        <= idle_d;
            lock_q        <= lock_d;
            fail_q        <= fail_d;
            check_en_q    <= check_en_d;
            check_match_q <= check_match_d;
            locked_out_q  <= locked_out_d;
            busy_q        <= busy_d;
        end
    end

    assign check_en    = check_en_q;
    assign check_match = check_match_q;
    assign digit_count = cnt_q;
    assign fail_count  = fail_q;
    assign locked_out  = locked_out_q;
    assign busy        = busy_q;

endmodule
